maf_cs_resolve: RTL and testbench
=================================

# maf_cs_resolve

Multi-cycle carry-save resolver for the MAF datapath. It sits downstream of the T3 pipeline registers and consumes the 48-bit Carry/Sum vector pair they deliver. It adds the pair in four 12-bit slices, optionally counts leading zeros of the result, and presents the resolved sum with exponent and sign/sticky sideband to the normalisation stage. A valid/ready handshake is used on both sides.

## Interface
Parameters: none; widths are fixed by the MAF datapath.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream operand valid
- in_ready  out  1  block accepts an operand this cycle
- Carry_in  in  48  carry vector of the carry-save pair
- Sum_in  in  48  sum vector of the carry-save pair
- E_in  in  12  exponent, passed through
- sign_in  in  1  result sign, passed through
- sti_in  in  4  partial sticky bits
- flush  in  1  synchronous abort of any operation in progress
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- sum_out  out  48  Carry_in + Sum_in, modulo 2^48
- cout_out  out  1  carry out of bit 47
- E_out  out  12  latched E_in
- sign_out  out  1  latched sign_in
- sticky_out  out  1  OR-reduction of latched sti_in
- lzc_out  out  6  leading-zero count of sum_out, range 0..48
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ADD, LZC (present only with MAF_LZC_EN), HOLD.
- in_ready = (state == IDLE), combinational. It is 1 during reset.
- IDLE: on in_valid & in_ready, latch Carry_in, Sum_in, E_in, sign_in and |sti_in. Clear slice counter k and the internal carry. Go to ADD.
- ADD: each cycle computes {c, sum[12k+11:12k]} = C[12k+11:12k] + S[12k+11:12k] + c, then increments k.
  - After k = 3: cout_out = c. Go to LZC if MAF_LZC_EN is defined, else HOLD.
- LZC: lzc_out = number of leading zeros of sum_out. All-zero sum gives 48. Go to HOLD.
- HOLD: out_valid = 1. Outputs stay stable while out_ready = 0. On out_ready, go to IDLE.
  - No new operand is accepted in the HOLD->IDLE cycle; in_ready rises the cycle after.
- flush (sampled each edge; takes priority over every other transition): state goes to IDLE next edge and out_valid drops. Data registers keep their contents and are not cleared.
- flush in IDLE together with in_valid: the operand is not accepted.
- Arithmetic: unsigned 48-bit, modulo 2^48. The overflow bit goes to cout_out only. No sign interpretation.

## Timing
- Reset values: sum_out 0, cout_out 0, E_out 0, sign_out 0, sticky_out 0, lzc_out 0, out_valid 0, busy 0, state IDLE, k 0.
- Reset mid-operation aborts immediately. No result is emitted after rstn releases.
- Latency: the accept edge is t0. Slices resolve at edges t1..t4.
  - With MAF_LZC_EN, LZC resolves at t5 and out_valid is high after t5 (5 cycles).
  - Without MAF_LZC_EN, out_valid is high after t4 (4 cycles).
- Best-case throughput is one operation per latency + 2 cycles: HOLD for 1 cycle, then the IDLE accept cycle.
- out_valid falls on the edge where out_valid & out_ready are both high.
- busy is registered-state decoded and glitch-free.

## Configuration
- MAF_LZC_EN defined:
  - The LZC state and the leading-zero counter are built.
  - lzc_out is valid with out_valid.
  - Latency is 5 cycles.
- MAF_LZC_EN undefined:
  - No LZC state or counter logic.
  - lzc_out is tied to 6'd0.
  - ADD goes directly to HOLD.
  - Latency is 4 cycles.

## Test plan
- Basic add: Carry=48'h0000_0000_0003, Sum=48'h0000_0000_0004 -> sum_out 48'h7, cout_out 0. With MAF_LZC_EN, lzc_out 45 and out_valid 5 cycles after accept.
- Slice carry chain: Carry=48'h0000_FFFF_FFFF, Sum=48'h1 -> sum_out 48'h0001_0000_0000, cout_out 0. With MAF_LZC_EN, lzc_out 15.
- Wrap: Carry=48'hFFFF_FFFF_FFFF, Sum=48'h1, sti_in=4'b0100, E_in=12'h3FF, sign_in=1 -> sum_out 0, cout_out 1, sticky_out 1, E_out 12'h3FF, sign_out 1. With MAF_LZC_EN, lzc_out 48.
- Backpressure: out_ready held low 10 cycles -> outputs stable and in_ready 0 throughout. out_ready pulse -> out_valid drops next edge; in_ready returns 1 one cycle later.
- flush asserted at edge t2 mid-ADD -> state IDLE, out_valid never asserts. A following operand Carry=5, Sum=6 yields sum_out 11 with normal latency.
- Async reset with rstn low at t3 mid-ADD -> all outputs read reset values immediately. After release, no stale out_valid and in_ready = 1.

Source files
------------

// File: rtl/maf_cs_resolve.sv
// maf_cs_resolve
//   Multi-cycle carry-save resolver for the MAF datapath. Adds the 48-bit
//   Carry/Sum pair in four 12-bit slices (LSB slice first), optionally
//   counts leading zeros of the result, and holds the resolved sum with
//   exponent and sign/sticky sideband until the normalisation stage takes it.
//
//   Optional feature: define MAF_LZC_EN to build the LZC state and the
//   leading-zero counter (latency 5). Undefined: lzc_out is 0, latency 4.
//
// Ports
//   clk, rstn            clock (rising edge), async active-low reset
//   in_valid/in_ready    upstream handshake (in_ready = state is IDLE)
//   Carry_in, Sum_in     48-bit carry-save pair
//   E_in, sign_in        exponent and sign, passed through
//   sti_in               partial sticky bits, OR-reduced on accept
//   flush                synchronous abort, highest priority
//   out_valid/out_ready  downstream handshake
//   sum_out, cout_out    Carry_in + Sum_in mod 2^48, carry out of bit 47
//   E_out, sign_out      latched E_in, sign_in
//   sticky_out           latched |sti_in
//   lzc_out              leading zeros of sum_out (0..48)
//   busy                 high in any state other than IDLE
module maf_cs_resolve (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] Carry_in,
   input  logic [47:0] Sum_in,
   input  logic [11:0] E_in,
   input  logic        sign_in,
   input  logic [3:0]  sti_in,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [47:0] sum_out,
   output logic        cout_out,
   output logic [11:0] E_out,
   output logic        sign_out,
   output logic        sticky_out,
   output logic [5:0]  lzc_out,
   output logic        busy
);

`ifdef MAF_LZC_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, LZC = 2'd2, HOLD = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, HOLD = 2'd3} state_t;
`endif

   state_t      state;
   logic [47:0] c_q;
   logic [47:0] s_q;
   logic [1:0]  k;
   logic        carry;

   logic [5:0]  base;
   logic [11:0] c_slice;
   logic [11:0] s_slice;
   logic [12:0] slice_sum;

   assign in_ready = (state == IDLE);

   always_comb begin
      base      = {4'd0, k} * 6'd12;
      c_slice   = c_q[base +: 12];
      s_slice   = s_q[base +: 12];
      slice_sum = {1'b0, c_slice} + {1'b0, s_slice} + {12'd0, carry};
   end

`ifdef MAF_LZC_EN
   logic [5:0] lzc_next;

   // Scanning upward lets the highest set bit win; no set bit leaves 48.
   always_comb begin
      lzc_next = 6'd48;
      for (int unsigned i = 0; i < 48; i++) begin
         if (sum_out[i]) lzc_next = 6'(47 - i);
      end
   end
`else
   assign lzc_out = 6'd0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         c_q        <= '0;
         s_q        <= '0;
         k          <= '0;
         carry      <= 1'b0;
         sum_out    <= '0;
         cout_out   <= 1'b0;
         E_out      <= '0;
         sign_out   <= 1'b0;
         sticky_out <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
`ifdef MAF_LZC_EN
         lzc_out    <= '0;
`endif
      end else if (flush) begin
         // Abort only the control path; data registers keep their contents.
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  c_q        <= Carry_in;
                  s_q        <= Sum_in;
                  E_out      <= E_in;
                  sign_out   <= sign_in;
                  sticky_out <= |sti_in;
                  k          <= '0;
                  carry      <= 1'b0;
                  state      <= ADD;
                  busy       <= 1'b1;
               end
            end
            ADD: begin
               sum_out[base +: 12] <= slice_sum[11:0];
               carry               <= slice_sum[12];
               k                   <= k + 2'd1;
               if (k == 2'd3) begin
                  cout_out <= slice_sum[12];
`ifdef MAF_LZC_EN
                  state    <= LZC;
`else
                  state     <= HOLD;
                  out_valid <= 1'b1;
`endif
               end
            end
`ifdef MAF_LZC_EN
            LZC: begin
               lzc_out   <= lzc_next;
               state     <= HOLD;
               out_valid <= 1'b1;
            end
`endif
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maf_cs_resolve.sv
module tb_maf_cs_resolve;

`ifdef MAF_LZC_EN
   localparam int LAT = 5;
   localparam bit LZC_ON = 1'b1;
`else
   localparam int LAT = 4;
   localparam bit LZC_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [47:0] Carry_in = '0;
   logic [47:0] Sum_in = '0;
   logic [11:0] E_in = '0;
   logic        sign_in = 1'b0;
   logic [3:0]  sti_in = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [47:0] sum_out;
   logic        cout_out;
   logic [11:0] E_out;
   logic        sign_out;
   logic        sticky_out;
   logic [5:0]  lzc_out;
   logic        busy;

   maf_cs_resolve dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready),
      .Carry_in(Carry_in), .Sum_in(Sum_in), .E_in(E_in),
      .sign_in(sign_in), .sti_in(sti_in), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum_out(sum_out), .cout_out(cout_out), .E_out(E_out),
      .sign_out(sign_out), .sticky_out(sticky_out),
      .lzc_out(lzc_out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] sum;
      logic        cout;
      logic [11:0] e;
      logic        sg;
      logic        st;
      logic [5:0]  lzc;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   rand_ready = 1'b0;
   bit   ready_force = 1'b1;
   logic ov_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: plain 49-bit addition, leading zeros by scanning from the MSB.
   function automatic exp_t model(input logic [47:0] c, input logic [47:0] s,
                                  input logic [11:0] e, input logic sg, input logic [3:0] sti);
      exp_t r;
      logic [48:0] full;
      int n;
      full = {1'b0, c} + {1'b0, s};
      n = 0;
      for (int b = 47; b >= 0; b--) begin
         if (full[b]) break;
         n++;
      end
      r.sum  = full[47:0];
      r.cout = full[48];
      r.e    = e;
      r.sg   = sg;
      r.st   = (sti != 4'd0);
      r.lzc  = LZC_ON ? 6'(n) : 6'd0;
      r.acc  = 0;
      return r;
   endfunction

   // Monitor: latency on the rising edge of out_valid, contents at handshake.
   always @(negedge clk) begin
      if (rstn) begin
         if (out_valid && !ov_prev) begin
            if (q.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            else chk("latency", 64'(cyc - q[0].acc), 64'(LAT));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_handshake", 64'(out_valid), 64'd0);
            end else begin
               chk("sum_out", 64'(sum_out), 64'(q[0].sum));
               chk("cout_out", 64'(cout_out), 64'(q[0].cout));
               chk("E_out", 64'(E_out), 64'(q[0].e));
               chk("sign_out", 64'(sign_out), 64'(q[0].sg));
               chk("sticky_out", 64'(sticky_out), 64'(q[0].st));
               chk("lzc_out", 64'(lzc_out), 64'(q[0].lzc));
               void'(q.pop_front());
            end
         end
      end
      ov_prev = rstn ? out_valid : 1'b0;
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic do_op(input logic [47:0] c, input logic [47:0] s, input logic [11:0] e,
                        input logic sg, input logic [3:0] sti, input bit push);
      exp_t x;
      bit ok;
      Carry_in = c; Sum_in = s; E_in = e; sign_in = sg; sti_in = sti;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
      else if (push) begin
         x = model(c, s, e, sg, sti);
         x.acc = cyc;
         q.push_back(x);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_queue_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      exp_t x;
      logic [47:0] c, s;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_sum", 64'(sum_out), 64'd0);
      chk("rst_side", 64'({cout_out, E_out, sign_out, sticky_out, lzc_out}), 64'd0);
      #20;
      rstn = 1'b1;
      @(posedge clk); #1;

      // Directed cases from the plan
      do_op(48'h3, 48'h4, 12'h010, 1'b0, 4'b0000, 1'b1);
      drain();
      do_op(48'h0000_FFFF_FFFF, 48'h1, 12'h020, 1'b0, 4'b0000, 1'b1);
      drain();
      do_op(48'hFFFF_FFFF_FFFF, 48'h1, 12'h3FF, 1'b1, 4'b0100, 1'b1);
      drain();

      // Backpressure: hold 10 cycles, then a single ready pulse
      ready_force = 1'b0;
      @(posedge clk); #1;
      do_op(48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 12'h155, 1'b1, 4'b0001, 1'b1);
      x = model(48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 12'h155, 1'b1, 4'b0001);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_sum_stable", 64'(sum_out), 64'(x.sum));
      end
      ready_force = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      ready_force = 1'b0;
      @(negedge clk);
      chk("bp_valid_dropped", 64'(out_valid), 64'd0);
      chk("bp_in_ready_back", 64'(in_ready), 64'd1);
      ready_force = 1'b1;
      @(posedge clk); #1;

      // Flush sampled at t2
      do_op(48'hABCD, 48'h1111, 12'h001, 1'b0, 4'b0000, 1'b0);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 10; i++) @(posedge clk);
      #1;
      // flush together with in_valid in IDLE: not accepted
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_no_accept", 64'(busy), 64'd0);
      do_op(48'd5, 48'd6, 12'h002, 1'b0, 4'b0000, 1'b1);
      drain();

      // Async reset mid-ADD at t3
      do_op(48'h7777, 48'h8888, 12'h7AB, 1'b1, 4'b1000, 1'b0);
      @(posedge clk); @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_sum", 64'(sum_out), 64'd0);
      chk("arst_side", 64'({cout_out, E_out, sign_out, sticky_out, lzc_out}), 64'd0);
      #14;
      rstn = 1'b1;
      for (int i = 0; i < 10; i++) @(posedge clk);
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_busy", 64'(busy), 64'd0);

      // Randomized traffic with random backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         c = {$urandom, $urandom};
         s = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            1: begin c = c >> $urandom_range(0, 47); s = s >> $urandom_range(0, 47); end
            2: begin c = '1; s = s >> $urandom_range(0, 47); end
            3: s = ~c + 48'd1;
            default: ;
         endcase
         do_op(c, s, 12'($urandom), 1'($urandom), 4'($urandom), 1'b1);
      end
      drain();
      rand_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
